// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU main control unit (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback and drives every
// datapath enable and mux select from the current state.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset to FETCH
//   opcode[5:0]       IR[31:26], used in DECODE and MEM_ADDR
//   zero              ALU zero flag, used in BRANCH
//   mem_ready         memory completes current access this cycle
//   PC_enable, PCSource[1:0]          PC load enable / PC_in select
//   IorD, MemRead, MemWrite, IRWrite  memory side controls
//   MemtoReg, RegDst, RegWrite        register file controls
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0] ALU input/op selects
//   illegal_op        one-cycle pulse on unsupported opcode in DECODE
//   state_out         current state, for debug
//
// Optional feature: define MC_IMM_ARITH_EN to add addi (opcode 0x08)
// through IMM_EXEC / IMM_WB. Without it 0x08 is an illegal opcode.

module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PC_enable,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        IMM_EXEC  = 4'd10,
        IMM_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_IMM_ARITH_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

    state_t state;
    state_t next_state;
    state_t dec_state;

    // Write-type strobes before reset gating.
    logic pc_en_raw;
    logic irw_raw;
    logic mw_raw;
    logic rw_raw;
    logic ill_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // During reset the non-write outputs show the FETCH decode.
        dec_state  = reset ? FETCH : state;
        next_state = FETCH;
        pc_en_raw  = 1'b0;
        irw_raw    = 1'b0;
        mw_raw     = 1'b0;
        rw_raw     = 1'b0;
        ill_raw    = 1'b0;
        PCSource   = 2'd0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;

        case (dec_state)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'd1;
                pc_en_raw  = mem_ready;
                irw_raw    = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ALUSrcB = 2'd3;
                case (opcode)
                    OP_RTYPE:      next_state = EXECUTE;
                    OP_LW, OP_SW:  next_state = MEM_ADDR;
                    OP_BEQ:        next_state = BRANCH;
                    OP_J:          next_state = JUMP;
`ifdef MC_IMM_ARITH_EN
                    OP_ADDI:       next_state = IMM_EXEC;
`endif
                    default: begin
                        ill_raw    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                rw_raw     = 1'b1;
                MemtoReg   = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                mw_raw     = 1'b1;
                IorD       = 1'b1;
                next_state = mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'd2;
                next_state = R_WB;
            end
            R_WB: begin
                rw_raw     = 1'b1;
                RegDst     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'd1;
                PCSource   = 2'd1;
                pc_en_raw  = zero;
                next_state = FETCH;
            end
            JUMP: begin
                PCSource   = 2'd2;
                pc_en_raw  = 1'b1;
                next_state = FETCH;
            end
`ifdef MC_IMM_ARITH_EN
            IMM_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                next_state = IMM_WB;
            end
            IMM_WB: begin
                rw_raw     = 1'b1;
                next_state = FETCH;
            end
`endif
            default: begin
                next_state = FETCH;
            end
        endcase

        PC_enable  = pc_en_raw & ~reset;
        IRWrite    = irw_raw & ~reset;
        MemWrite   = mw_raw & ~reset;
        RegWrite   = rw_raw & ~reset;
        illegal_op = ill_raw & ~reset;
    end

    assign state_out = STATE_W'(state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: self-checking bench for mc_control_fsm.
// Builds per-cycle expected traces from instruction-level rules.

module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PC_enable;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic [3:0] state_out;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PC_enable  (PC_enable),
        .PCSource   (PCSource),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    // Control word packing:
    // {PC_enable, PCSource, IorD, MemRead, MemWrite, IRWrite,
    //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op}
    typedef struct {
        string      name;
        logic       rst;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [3:0] st;
        logic [15:0] ctl;
    } vec_t;

    vec_t vq[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] cw(
        input logic pce, input logic [1:0] pcs, input logic iord,
        input logic mrd, input logic mwr, input logic irw,
        input logic m2r, input logic rd, input logic rw,
        input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic ill);
        return {pce, pcs, iord, mrd, mwr, irw, m2r, rd, rw,
                asa, asb, aop, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input string nm, input logic rst,
        input logic mr, input logic z, input logic [5:0] op,
        input logic [3:0] st, input logic [15:0] ctl);
        vec_t v;
        v.name = nm; v.rst = rst; v.mr = mr; v.z = z;
        v.op = op; v.st = st; v.ctl = ctl;
        vq.push_back(v);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        if (op == 6'h00 || op == 6'h23 || op == 6'h2B) return 1'b1;
        if (op == 6'h04 || op == 6'h02) return 1'b1;
`ifdef MC_IMM_ARITH_EN
        if (op == 6'h08) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // FETCH: fw stalled cycles, then the cycle that loads IR and PC.
    function automatic void add_fetch(input string nm,
        input logic [5:0] op, input int fw);
        for (int i = 0; i < fw; i++)
            push({nm, ".fetch_wait"}, 0, 0, rbit(), op, 4'd0,
                 cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        push({nm, ".fetch"}, 0, 1, rbit(), op, 4'd0,
             cw(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    endfunction

    // One whole instruction; zb < 0 gives a random zero flag in BRANCH.
    function automatic void add_instr(input string nm,
        input logic [5:0] op, input int fw, input int mw, input int zb);
        logic z;
        add_fetch(nm, op, fw);
        if (!is_legal(op)) begin
            push({nm, ".decode_ill"}, 0, rbit(), rbit(), op, 4'd1,
                 cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
            return;
        end
        push({nm, ".decode"}, 0, rbit(), rbit(), op, 4'd1,
             cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        case (op)
            6'h00: begin
                push({nm, ".exec"}, 0, rbit(), rbit(), op, 4'd6,
                     cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
                push({nm, ".r_wb"}, 0, rbit(), rbit(), op, 4'd7,
                     cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            6'h23: begin
                push({nm, ".addr"}, 0, rbit(), rbit(), op, 4'd2,
                     cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                for (int i = 0; i < mw; i++)
                    push({nm, ".rd_wait"}, 0, 0, rbit(), op, 4'd3,
                         cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                push({nm, ".rd"}, 0, 1, rbit(), op, 4'd3,
                     cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                push({nm, ".mem_wb"}, 0, rbit(), rbit(), op, 4'd4,
                     cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
            end
            6'h2B: begin
                push({nm, ".addr"}, 0, rbit(), rbit(), op, 4'd2,
                     cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                for (int i = 0; i < mw; i++)
                    push({nm, ".wr_wait"}, 0, 0, rbit(), op, 4'd5,
                         cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                push({nm, ".wr"}, 0, 1, rbit(), op, 4'd5,
                     cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            6'h04: begin
                z = (zb < 0) ? rbit() : 1'(zb);
                push({nm, ".branch"}, 0, rbit(), z, op, 4'd8,
                     cw(z, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            end
            6'h02: begin
                push({nm, ".jump"}, 0, rbit(), rbit(), op, 4'd9,
                     cw(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            default: begin
                push({nm, ".imm_exec"}, 0, rbit(), rbit(), op, 4'd10,
                     cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                push({nm, ".imm_wb"}, 0, rbit(), rbit(), op, 4'd11,
                     cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            end
        endcase
    endfunction

    function automatic void add_reset(input string nm,
        input logic [3:0] st);
        push(nm, 1, rbit(), rbit(), 6'h2B, st,
             cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    endfunction

    task automatic run_queue();
        logic [15:0] act;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset     = vq[i].rst;
            mem_ready = vq[i].mr;
            zero      = vq[i].z;
            opcode    = vq[i].op;
            #1;
            act = {PC_enable, PCSource, IorD, MemRead, MemWrite,
                   IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, illegal_op};
            n_cmp++;
            if (state_out !== vq[i].st) begin
                n_bad++;
                $display("FAIL %s[%0d] state: got %0d want %0d",
                         vq[i].name, i, state_out, vq[i].st);
            end
            n_cmp++;
            if (act !== vq[i].ctl) begin
                n_bad++;
                $display("FAIL %s[%0d] ctl: got %h want %h",
                         vq[i].name, i, act, vq[i].ctl);
            end
        end
        vq.delete();
    endtask

    logic [5:0] ops[7];
    logic [5:0] op_r;

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'h00;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};
        @(posedge clk);

        // Directed table: reset, release, then the listed corner cases.
        add_reset("reset0", 4'd0);
        add_reset("reset1", 4'd0);
        add_instr("rtype", 6'h00, 0, 0, -1);
        add_instr("lw_stall", 6'h23, 3, 2, -1);
        add_instr("beq_taken", 6'h04, 0, 0, 1);
        add_instr("beq_not", 6'h04, 0, 0, 0);
        add_instr("illegal", 6'h3F, 0, 0, -1);
        add_instr("j", 6'h02, 0, 0, -1);
        add_instr("sw", 6'h2B, 0, 1, -1);
        add_instr("addi", 6'h08, 0, 0, -1);
        // sw abandoned by reset while MEM_WRITE is stalled.
        add_fetch("sw_rst", 6'h2B, 0);
        push("sw_rst.decode", 0, 1, 0, 6'h2B, 4'd1,
             cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        push("sw_rst.addr", 0, 1, 0, 6'h2B, 4'd2,
             cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        push("sw_rst.wr_wait", 0, 0, 0, 6'h2B, 4'd5,
             cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add_reset("sw_rst.reset", 4'd5);
        add_instr("after_rst", 6'h00, 0, 0, -1);
        run_queue();

        // Randomized instruction stream with random memory stalls.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                op_r = 6'($urandom_range(0, 63));
            else
                op_r = ops[$urandom_range(0, 6)];
            add_instr("rand", op_r, $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
        end
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
